// File: rtl/ifu_pc_gen.sv
// ifu_pc_gen: fetch-stage front end.
// Owns the PC and issues one fetch address per cycle to the instruction read
// stage. Each returned word is paired with its PC and buffered, then handed to
// decode over a valid/ready handshake. A redirect reloads the PC and drops
// everything that is buffered or in flight.
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous, active-low reset
//   fetch_addr     fetch address (the pc register)
//   fetch_data     instruction word for the address issued one cycle earlier
//   redirect_valid flush and reload the PC
//   redirect_pc    new PC (low two bits forced to zero)
//   out_valid      buffer head is valid
//   out_pc         PC of the head entry (0 when empty)
//   out_inst       instruction of the head entry (NOP_INST when empty)
//   out_ready      decode accepts the head this cycle
module ifu_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] fetch_addr,
    input  logic [31:0] fetch_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    input  logic        out_ready
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = CW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t          buf_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   count;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     inflight_pc_q, inflight_pc_d;
    logic            inflight_valid_q, inflight_valid_d;
    logic            deq, enq, issue;
    logic [OW-1:0]   occupancy;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign count      = count_q;
    assign fetch_addr = pc_q;
    assign out_valid  = (count_q != '0);
    assign out_pc     = out_valid ? buf_q[head_q].pc   : 32'h0;
    assign out_inst   = out_valid ? buf_q[head_q].inst : NOP_INST;

    // Credit check: buffered + in-flight entries after this cycle's pop must
    // leave room for one more fetch, so the buffer can never overflow.
    always_comb begin
        deq       = out_valid & out_ready;
        enq       = inflight_valid_q & ~redirect_valid;
        occupancy = OW'(count_q) + OW'(inflight_valid_q) - OW'(deq);
        issue     = ~redirect_valid & (occupancy < OW'(DEPTH));
    end

    // Next-state for PC, in-flight tracker and buffer bookkeeping.
    always_comb begin
        pc_d             = pc_q;
        inflight_valid_d = 1'b0;
        inflight_pc_d    = inflight_pc_q;
        head_d           = head_q;
        tail_d           = tail_q;
        count_d          = count_q;

        if (redirect_valid) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (issue) begin
                inflight_valid_d = 1'b1;
                inflight_pc_d    = pc_q;
                pc_d             = pc_q + 32'd4;
            end
            if (enq) begin
                tail_d = ptr_inc(tail_q);
            end
            if (deq) begin
                head_d = ptr_inc(head_q);
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q             <= RESET_PC;
            inflight_valid_q <= 1'b0;
            inflight_pc_q    <= 32'h0;
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
        end else begin
            pc_q             <= pc_d;
            inflight_valid_q <= inflight_valid_d;
            inflight_pc_q    <= inflight_pc_d;
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
        end
    end

    // Buffer storage: write the returning word at the tail.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                buf_q[i] <= '0;
            end
        end else if (enq) begin
            buf_q[tail_q] <= '{pc: inflight_pc_q, inst: fetch_data};
        end
    end

endmodule

// File: tb/tb_ifu_pc_gen.sv
// Directed testbench for ifu_pc_gen. The memory model returns
// addr ^ 32'hFFFF_0000 one cycle after the address is sampled.
module tb_ifu_pc_gen;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] XOR_KEY  = 32'hFFFF_0000;

    logic        clock;
    logic        reset;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;

    int n_tests;
    int n_fail;

    ifu_pc_gen #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH),
        .NOP_INST (NOP_INST)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .fetch_addr     (fetch_addr),
        .fetch_data     (fetch_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_ready      (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Read stage: one-cycle latency.
    initial fetch_data = 32'h0;
    always @(posedge clock) fetch_data <= fetch_addr ^ XOR_KEY;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Occupancy must stay within [0, DEPTH].
    always @(negedge clock) begin
        if (reset) check("count_bound", 32'(dut.count <= DEPTH), 32'd1);
    end

    task automatic expect_empty(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_pc"},    out_pc,          32'h0);
        check({tag, "_inst"},  out_inst,        NOP_INST);
    endtask

    task automatic expect_entry(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_pc"},    out_pc,          pc);
        check({tag, "_inst"},  out_inst,        pc ^ XOR_KEY);
    endtask

    task automatic do_reset_release();
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        expect_empty("rst");
        check("rst_fetch_addr", fetch_addr, RESET_PC);
    endtask

    // Reset release with out_ready high: entry in cycle 2, then one per cycle.
    task automatic stream_from_reset();
        out_ready = 1'b1;
        do_reset_release();
        @(negedge clock);
        expect_empty("lat_c1");
        check("lat_c1_fetch_addr", fetch_addr, 32'h8000_0004);
        @(negedge clock);
        expect_entry("lat_c2", 32'h8000_0000);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clock);
            expect_entry("stream", 32'h8000_0000 + 32'(4 * i));
        end
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        reset          = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Scenario 1: streaming from reset.
        stream_from_reset();

        // Scenario 2: backpressure saturates the buffer, then drains in order.
        out_ready = 1'b0;
        do_reset_release();
        repeat (3) @(negedge clock);
        for (int i = 0; i < 10; i++) begin
            expect_entry("hold", 32'h8000_0000);
            check("hold_fetch_addr", fetch_addr, 32'h8000_0008);
            if (i < 9) @(negedge clock);
        end
        out_ready = 1'b1;
        @(negedge clock);
        expect_entry("drain1", 32'h8000_0004);
        @(negedge clock);
        expect_entry("drain2", 32'h8000_0008);
        @(negedge clock);
        expect_entry("drain3", 32'h8000_000C);

        // Scenario 3: redirect with two entries buffered, misaligned target.
        out_ready = 1'b0;
        do_reset_release();
        repeat (3) @(negedge clock);
        expect_entry("full", 32'h8000_0000);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0103;
        @(negedge clock);
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        expect_empty("redir_c1");
        check("redir_c1_fetch_addr", fetch_addr, 32'h8000_0100);
        @(negedge clock);
        expect_empty("redir_c2");
        @(negedge clock);
        expect_entry("redir_c3", 32'h8000_0100);
        @(negedge clock);
        expect_entry("redir_c4", 32'h8000_0104);

        // Scenario 4: redirect coinciding with a completed handshake.
        @(negedge clock);
        expect_entry("deq_redir", 32'h8000_0108);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        @(negedge clock);
        redirect_valid = 1'b0;
        expect_empty("dr_c1");
        @(negedge clock);
        expect_empty("dr_c2");
        @(negedge clock);
        expect_entry("dr_c3", 32'h8000_0200);
        @(negedge clock);
        expect_entry("dr_c4", 32'h8000_0204);

        // Scenario 6: PC wrap-around at the top of the address space.
        @(negedge clock);
        expect_entry("pre_wrap", 32'h8000_0208);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clock);
        redirect_valid = 1'b0;
        expect_empty("wrap_c1");
        check("wrap_c1_fetch_addr", fetch_addr, 32'hFFFF_FFFC);
        @(negedge clock);
        check("wrap_c2_fetch_addr", fetch_addr, 32'h0000_0000);
        @(negedge clock);
        expect_entry("wrap0", 32'hFFFF_FFFC);
        @(negedge clock);
        expect_entry("wrap1", 32'h0000_0000);
        @(negedge clock);
        expect_entry("wrap2", 32'h0000_0004);

        // Scenario 5: asynchronous reset mid-cycle with the buffer full.
        out_ready = 1'b0;
        do_reset_release();
        repeat (3) @(negedge clock);
        expect_entry("pre_async", 32'h8000_0000);
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        expect_empty("async_rst");
        check("async_rst_fetch_addr", fetch_addr, RESET_PC);
        stream_from_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
